digit_score_engine: RTL

//  Compute engine between the pixel buffer and the result registers of the digit-recognition accelerator.
//  On start, reads the 25-word pixel buffer and the signed weight ROM.

---
 rtl/digit_score_engine.sv | 103 ++++++++++
 1 files changed

// File: rtl/digit_score_engine.sv
// digit_score_engine: scores one image against N_OUT weight sets, saturates each score,
// writes it to score memory and reports the highest-scoring class.
module digit_score_engine #(
    parameter int N_IN  = 25,
    parameter int N_OUT = 10,
    parameter int DW    = 16,
    parameter int WW    = 8,
    parameter int ACCW  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    output logic [4:0]           o_pix_addr,
    input  logic [DW-1:0]        i_pix_data,
    output logic [7:0]           o_w_addr,
    input  logic signed [WW-1:0] i_w_data,
    output logic                 o_score_we,
    output logic [3:0]           o_score_addr,
    output logic [DW-1:0]        o_score_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [3:0]           o_class_id
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, STORE, FINISH} state_t;
    localparam logic [4:0] K_LAST = 5'(N_IN - 1);
    localparam logic [3:0] C_LAST = 4'(N_OUT - 1);
    state_t                 r_state, w_next;
    logic [4:0]             r_k, r_pix_addr;
    logic [3:0]             r_c, r_cls, r_class_id;
    logic [7:0]             r_w_addr, w_w_addr;
    logic signed [ACCW-1:0] r_acc, w_prod;
    logic signed [DW:0]     w_px;
    logic signed [DW-1:0]   r_best, w_sat;
    logic                   w_issue;
    assign w_issue  = (r_state == ISSUE);
    assign w_px     = {1'b0, i_pix_data};
    assign w_prod   = ACCW'(w_px) * ACCW'(i_w_data);
    assign w_w_addr = 8'(r_c) * 8'd25 + 8'(r_k);
    assign w_sat    = (r_acc > 32'sd32767) ? 16'sh7FFF :
                      (r_acc < -32'sd32768) ? 16'sh8000 : r_acc[15:0];
    // Addresses follow the counters while issuing and hold their last value otherwise.
    assign o_pix_addr   = w_issue ? r_k : r_pix_addr;
    assign o_w_addr     = w_issue ? w_w_addr : r_w_addr;
    assign o_score_we   = (r_state == STORE);
    assign o_score_addr = r_c;
    assign o_score_data = w_sat;
    assign o_busy       = w_issue || (r_state == DRAIN) || (r_state == STORE);
    assign o_done       = (r_state == FINISH);
    assign o_class_id   = r_class_id;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? ISSUE : IDLE;
            ISSUE:   w_next = (r_k == K_LAST) ? DRAIN : ISSUE;
            DRAIN:   w_next = STORE;
            STORE:   w_next = (r_c == C_LAST) ? FINISH : ISSUE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_c        <= '0;
            r_cls      <= '0;
            r_class_id <= '0;
            r_acc      <= '0;
            r_best     <= '0;
            r_pix_addr <= '0;
            r_w_addr   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (i_start) begin
                    r_k    <= '0;
                    r_c    <= '0;
                    r_cls  <= '0;
                    r_acc  <= '0;
                    r_best <= 16'sh8000;
                end
                ISSUE: begin
                    r_pix_addr <= r_k;
                    r_w_addr   <= w_w_addr;
                    if (r_k != 5'd0) r_acc <= r_acc + w_prod;
                    if (r_k != K_LAST) r_k <= r_k + 5'd1;
                end
                DRAIN: r_acc <= r_acc + w_prod;
                STORE: begin
                    // Strict compare so ties keep the lower class index.
                    if (w_sat > r_best) begin
                        r_best <= w_sat;
                        r_cls  <= r_c;
                    end
                    r_acc <= '0;
                    r_k   <= '0;
                    if (r_c != C_LAST) r_c <= r_c + 4'd1;
                end
                FINISH: r_class_id <= r_cls;
                default: ;
            endcase
        end
    end
endmodule
